btn_conditioner: RTL and testbench



---
 rtl/btn_conditioner.sv | 147 ++++++++++++++
 tb/tb_btn_conditioner.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-FF sync, counter debounce, press pulse, optional hold-to-repeat.
// Define BTN_AUTOREPEAT_EN to enable the repeat FSMs on L/R/D; otherwise every button pulses once per press.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 750000,
  parameter int unsigned REPEAT_DELAY    = 22500000,
  parameter int unsigned REPEAT_RATE     = 7500000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnD,
  input  logic       btnU,
  output logic       move_l,
  output logic       move_r,
  output logic       move_d,
  output logic       rot,
  output logic [3:0] btn_state
);

  localparam int unsigned CW = 25;

`ifdef BTN_AUTOREPEAT_EN
  localparam bit RepeatEn = 1'b1;
`else
  localparam bit RepeatEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rep_state_e;

  // Bit order everywhere is {U, D, R, L}
  logic [3:0]    raw;
  logic [3:0]    sync1_q;
  logic [3:0]    sync2_q;
  logic [3:0]    stable_q;
  logic [3:0]    stable_d;
  logic [3:0]    level_q;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];

  rep_state_e    state_q [3];
  rep_state_e    state_d [3];
  logic [CW-1:0] timer_q [3];
  logic [CW-1:0] timer_d [3];
  logic [2:0]    rep_pulse;

  logic [3:0]    press;
  logic [3:0]    pulse_d;
  logic          conflict;
  logic [3:0]    out_d;
  logic [3:0]    out_q;

  assign raw   = {btnU, btnD, btnR, btnL};
  assign press = stable_q & ~level_q;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Repeat pulses only fire while the debounced level is still high, so a release never pulses.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      state_d[i]   = state_q[i];
      timer_d[i]   = timer_q[i];
      rep_pulse[i] = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (press[i]) begin
            state_d[i] = DELAY;
            timer_d[i] = CW'(REPEAT_DELAY - 1);
          end
        end
        DELAY, REPEAT: begin
          if (!stable_q[i]) begin
            state_d[i] = IDLE;
            timer_d[i] = '0;
          end else if (timer_q[i] == '0) begin
            rep_pulse[i] = 1'b1;
            state_d[i]   = REPEAT;
            timer_d[i]   = CW'(REPEAT_RATE - 1);
          end else begin
            timer_d[i] = timer_q[i] - CW'(1);
          end
        end
        default: begin
          state_d[i] = IDLE;
          timer_d[i] = '0;
        end
      endcase
    end
  end

  // The L/R mask gates only the outputs; both FSMs keep their schedule underneath.
  always_comb begin
    conflict = stable_q[0] & stable_q[1];
    pulse_d  = press | {1'b0, rep_pulse & {3{RepeatEn}}};
    out_d    = pulse_d & ~{2'b00, conflict, conflict};
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      level_q  <= '0;
      out_q    <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
      for (int unsigned i = 0; i < 3; i++) begin
        state_q[i] <= IDLE;
        timer_q[i] <= '0;
      end
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      level_q  <= stable_q;
      out_q    <= out_d;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      for (int unsigned i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
    end
  end

  assign {rot, move_d, move_r, move_l} = out_q;
  assign btn_state = level_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: window-based behavioural model checked every cycle plus directed pulse-time lists.
module tb_btn_conditioner;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 3;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       pclk = 1'b0;
  logic       rst  = 1'b1;
  logic       btnL = 1'b0, btnR = 1'b0, btnD = 1'b0, btnU = 1'b0;
  logic       move_l, move_r, move_d, rot;
  logic [3:0] btn_state;

  int n_tests = 0;
  int n_fail  = 0;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .pclk     (pclk),
    .rst      (rst),
    .btnL     (btnL),
    .btnR     (btnR),
    .btnD     (btnD),
    .btnU     (btnU),
    .move_l   (move_l),
    .move_r   (move_r),
    .move_d   (move_d),
    .rot      (rot),
    .btn_state(btn_state)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // Model: stable flips when the last D synchronised samples all differ from it;
  // pulses at rise+1, then (repeat build, L/R/D) at rise+1+RD+n*RR while held.
  bit   m_s1 [4];
  bit   m_st [4];
  bit   m_h  [4][D];
  int   m_rise [4];
  int   ecnt = 0;
  logic [3:0] exp_bs;
  logic exp_l, exp_r, exp_d, exp_u;
  bit   model_ok = 1'b0;

  always @(posedge pclk) begin : model
    bit raw [4];
    bit pl  [4];
    bit fl;
    bit cf;
    raw[0] = btnL; raw[1] = btnR; raw[2] = btnD; raw[3] = btnU;
    ecnt = ecnt + 1;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_s1[i] = 1'b0;
        m_st[i] = 1'b0;
        m_rise[i] = 0;
        for (int j = 0; j < D; j++) m_h[i][j] = 1'b0;
      end
      exp_bs = '0;
      exp_l = 1'b0; exp_r = 1'b0; exp_d = 1'b0; exp_u = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp_bs[i] = m_st[i];
        pl[i] = m_st[i] && ((ecnt == m_rise[i] + 1) ||
                (REP && i < 3 && ecnt >= m_rise[i] + 1 + RD &&
                 ((ecnt - m_rise[i] - 1 - RD) % RR) == 0));
        fl = 1'b1;
        for (int j = 0; j < D; j++) if (m_h[i][j] == m_st[i]) fl = 1'b0;
        for (int j = D - 1; j > 0; j--) m_h[i][j] = m_h[i][j-1];
        m_h[i][0] = m_s1[i];
        m_s1[i] = raw[i];
        if (fl) begin
          m_st[i] = !m_st[i];
          if (m_st[i]) m_rise[i] = ecnt;
        end
      end
      cf = exp_bs[0] & exp_bs[1];
      exp_l = pl[0] & !cf;
      exp_r = pl[1] & !cf;
      exp_d = pl[2];
      exp_u = pl[3];
    end
    model_ok = 1'b1;
  end

  always @(negedge pclk) begin
    if (model_ok) begin
      n_tests++;
      if ({move_l, move_r, move_d, rot, btn_state} !== {exp_l, exp_r, exp_d, exp_u, exp_bs}) begin
        n_fail++;
        if (n_fail <= 30)
          $display("FAIL cycle_cmp cyc=%0d got l%b r%b d%b u%b st%b required l%b r%b d%b u%b st%b",
                   cyc, move_l, move_r, move_d, rot, btn_state,
                   exp_l, exp_r, exp_d, exp_u, exp_bs);
      end
    end
  end

  // Pulse recorder, times relative to the edge that first samples the stimulus
  bit rec_on = 1'b0;
  int t0 = 0;
  int q_l[$], q_r[$], q_d[$], q_u[$];
  int bs_first [4];

  always @(negedge pclk) begin
    if (rec_on) begin
      if (move_l) q_l.push_back(cyc - t0);
      if (move_r) q_r.push_back(cyc - t0);
      if (move_d) q_d.push_back(cyc - t0);
      if (rot)    q_u.push_back(cyc - t0);
      for (int i = 0; i < 4; i++)
        if (btn_state[i] && bs_first[i] < 0) bs_first[i] = cyc - t0;
    end
  end

  task automatic start_test();
    @(negedge pclk);
    q_l.delete(); q_r.delete(); q_d.delete(); q_u.delete();
    for (int i = 0; i < 4; i++) bs_first[i] = -1;
    t0 = cyc + 1;
    rec_on = 1'b1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic check_q(input string name, input int got[$], input int req[$]);
    bit ok;
    ok = (got.size() == req.size());
    if (ok) for (int i = 0; i < got.size(); i++) if (got[i] != req[i]) ok = 1'b0;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s got=%p required=%p", name, got, req);
    end
  endtask

  task automatic check_int(input string name, input int got, input int req);
    n_tests++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  initial begin
    int req[$];
    int empty_q[$];
    rst = 1'b1;
    wait_cyc(3);
    check_int("reset_outputs", {28'd0, move_l, move_r, move_d, rot} + 32'(btn_state), 0);
    rst = 1'b0;
    wait_cyc(5);

    // 1: btnU held -> single rot pulse after edge 6, btn_state[3] from edge 6
    start_test();
    btnU = 1'b1;
    wait_cyc(20);
    btnU = 1'b0;
    wait_cyc(20);
    req = '{6};
    check_q("t1_rot", q_u, req);
    check_int("t1_state_u_first", bs_first[3], 6);

    // 2: glitchy btnL shorter than the debounce window
    start_test();
    btnL = 1'b1; wait_cyc(3);
    btnL = 1'b0; wait_cyc(2);
    btnL = 1'b1; wait_cyc(3);
    btnL = 1'b0; wait_cyc(15);
    check_q("t2_move_l", q_l, empty_q);
    check_int("t2_state_l_first", bs_first[0], -1);

    // 3: btnD held 30 cycles, repeat schedule and silent release
    start_test();
    btnD = 1'b1; wait_cyc(30);
    btnD = 1'b0; wait_cyc(20);
    if (REP) req = '{6, 16, 19, 22, 25, 28, 31, 34};
    else     req = '{6};
    check_q("t3_move_d", q_d, req);

    // 4: L held, R joins at 20 and leaves at 40, L released at 50
    start_test();
    btnL = 1'b1; wait_cyc(20);
    btnR = 1'b1; wait_cyc(20);
    btnR = 1'b0; wait_cyc(10);
    btnL = 1'b0; wait_cyc(20);
    if (REP) req = '{6, 16, 19, 22, 25, 46, 49, 52, 55};
    else     req = '{6};
    check_q("t4_move_l", q_l, req);
    check_q("t4_move_r", q_r, empty_q);

    // 5: reset pulse while btnR is repeating
    start_test();
    btnR = 1'b1; wait_cyc(20);
    rst = 1'b1; wait_cyc(1);
    rst = 1'b0;
    check_int("t5_after_reset", {27'd0, move_l, move_r, move_d, rot, 1'b0} + 32'(btn_state), 0);
    wait_cyc(25);
    btnR = 1'b0; wait_cyc(20);
    if (REP) req = '{6, 16, 19, 27, 37, 40, 43, 46, 49};
    else     req = '{6, 27};
    check_q("t5_move_r", q_r, req);

    // 6: btnR held 40 cycles
    start_test();
    btnR = 1'b1; wait_cyc(40);
    btnR = 1'b0; wait_cyc(20);
    if (REP) req = '{6, 16, 19, 22, 25, 28, 31, 34, 37, 40, 43};
    else     req = '{6};
    check_q("t6_move_r", q_r, req);
    check_q("t6_move_l", q_l, empty_q);

    rec_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
